// File: rtl/rex_pkg.sv
`default_nettype none
// ============================================================================
// rex_pkg : shared encodings and period helper for the Rex frame scheduler
// Rev 1.0
// ============================================================================
package rex_pkg;

    localparam int LEVEL_W = 3;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_RUN   = 2'd1,
        GS_PAUSE = 2'd2,
        GS_OVER  = 2'd3
    } game_state_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PHYS   = 3'd1,
        S_SCROLL = 3'd2,
        S_SCORE  = 3'd3,
        S_RENDER = 3'd4
    } seq_state_e;

    function automatic logic [15:0] frame_period(input int div, input int step,
                                                 input logic [LEVEL_W-1:0] lvl);
        return 16'(div - step * int'(lvl));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rex_frame_timer.sv
`default_nettype none
// ============================================================================
// rex_frame_timer : programmable-period counter, period latched at each wrap
// Rev 1.0
// ============================================================================
module rex_frame_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic [15:0] period_i,
    output logic        tick_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [15:0] period_q;
    logic [15:0] period_d;

    assign tick_o = en_i && (count_q == period_q - 16'd1);

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        if (clr_i || tick_o) begin
            count_d  = 16'd0;
            period_d = period_i;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 16'd0;
            period_q <= 16'd0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rex_frame_scheduler.sv
`default_nettype none
// ============================================================================
// rex_frame_scheduler : game run state, speed level and per-frame strobe sequencer
// Optional macro REX_SCHED_STEP_EN adds step_btn (single-frame step in PAUSE).
// Rev 1.0
// ============================================================================
module rex_frame_scheduler
    import rex_pkg::*;
#(
    parameter int FRAME_DIV    = 5000,
    parameter int SPEED_STEP   = 250,
    parameter int LEVEL_FRAMES = 256,
    parameter int LEVEL_MAX    = 7
) (
    input  logic               clk120kHz,
    input  logic               rstn,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               collide,
    input  logic               render_ack,
`ifdef REX_SCHED_STEP_EN
    input  logic               step_btn,
`endif
    output logic               phys_stb,
    output logic               scroll_stb,
    output logic               score_stb,
    output logic               render_req,
    output logic [1:0]         game_state,
    output logic [LEVEL_W-1:0] level,
    output logic               overrun
);

    localparam int LFC_W = (LEVEL_FRAMES > 1) ? $clog2(LEVEL_FRAMES) : 1;

    game_state_e        gs_q, gs_d;
    seq_state_e         seq_q, seq_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LFC_W-1:0]   lfc_q, lfc_d;
    logic               overrun_q, overrun_d;
    logic               restart;
    logic               run_en;
    logic               tick;
    logic               step_go;
    logic [15:0]        period;

    always_comb begin
        gs_d    = gs_q;
        restart = 1'b0;
        case (gs_q)
            GS_IDLE, GS_OVER: begin
                if (start_btn) begin
                    gs_d    = GS_RUN;
                    restart = 1'b1;
                end
            end
            GS_RUN: begin
                if (collide)        gs_d = GS_OVER;
                else if (pause_btn) gs_d = GS_PAUSE;
            end
            GS_PAUSE: begin
                if (pause_btn) gs_d = GS_RUN;
            end
            default: gs_d = GS_IDLE;
        endcase
    end

    // Counting stops on the very cycle RUN is left, so a collide or pause
    // coinciding with a wrap discards that tick and freezes the count.
    assign run_en = (gs_q == GS_RUN) && (gs_d == GS_RUN);
    assign period = frame_period(FRAME_DIV, SPEED_STEP, level_d);

`ifdef REX_SCHED_STEP_EN
    assign step_go = (gs_q == GS_PAUSE) && (seq_q == S_IDLE) && step_btn;
`else
    assign step_go = 1'b0;
`endif

    rex_frame_timer u_timer (
        .clk      (clk120kHz),
        .rst_n    (rstn),
        .en_i     (run_en),
        .clr_i    (restart),
        .period_i (period),
        .tick_o   (tick)
    );

    always_comb begin
        seq_d     = seq_q;
        overrun_d = overrun_q;
        case (seq_q)
            S_IDLE:   if (tick || step_go) seq_d = S_PHYS;
            S_PHYS:   seq_d = S_SCROLL;
            S_SCROLL: seq_d = S_SCORE;
            S_SCORE:  seq_d = S_RENDER;
            S_RENDER: if (render_ack) seq_d = S_IDLE;
            default:  seq_d = S_IDLE;
        endcase
        if (tick && (seq_q != S_IDLE)) overrun_d = 1'b1;
        if (restart)                   overrun_d = 1'b0;
    end

    always_comb begin
        level_d = level_q;
        lfc_d   = lfc_q;
        if (restart) begin
            level_d = '0;
            lfc_d   = '0;
        end else if ((seq_q == S_RENDER) && render_ack) begin
            if (lfc_q == LFC_W'(LEVEL_FRAMES - 1)) begin
                lfc_d = '0;
                if (level_q != LEVEL_W'(LEVEL_MAX)) level_d = level_q + 1'b1;
            end else begin
                lfc_d = lfc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk120kHz or negedge rstn) begin
        if (!rstn) begin
            gs_q      <= GS_IDLE;
            seq_q     <= S_IDLE;
            level_q   <= '0;
            lfc_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            gs_q      <= gs_d;
            seq_q     <= seq_d;
            level_q   <= level_d;
            lfc_q     <= lfc_d;
            overrun_q <= overrun_d;
        end
    end

    assign phys_stb   = (seq_q == S_PHYS);
    assign scroll_stb = (seq_q == S_SCROLL);
    assign score_stb  = (seq_q == S_SCORE);
    assign render_req = (seq_q == S_RENDER);
    assign game_state = gs_q;
    assign level      = level_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: doc/rex_frame_scheduler.md
Name: rex_frame_scheduler

Overview:
- Master game-frame scheduler for the Rex Runner core, running directly on the 120 kHz system clock.
- Generates the frame tick internally with a programmable divider; no derived clocks are used.
- Each frame it fires one-cycle update strobes in a fixed order (physics, scroll, score), then holds a render request until the renderer acknowledges.
- Owns the game run state (idle/run/pause/over) and the speed level, which shortens the frame period as play continues.

Parameters:
- FRAME_DIV, 5000: frame period in clk120kHz cycles at level 0 (24 Hz).
- SPEED_STEP, 250: period reduction per speed level.
- LEVEL_FRAMES, 256: completed frames per level increment.
- LEVEL_MAX, 7: saturating maximum level (3-bit).

Ports:
- clk120kHz  in  1  system clock, 120 kHz.
- rstn  in  1  asynchronous active-low reset; all flops clear on its falling edge.
- start_btn  in  1  one-cycle debounced start pulse.
- pause_btn  in  1  one-cycle debounced pause toggle.
- collide  in  1  collision flag from the physics block, level-sensitive.
- render_ack  in  1  one-cycle completion pulse from the renderer.
- phys_stb  out  1  one-cycle physics update strobe.
- scroll_stb  out  1  one-cycle obstacle/ground scroll strobe.
- score_stb  out  1  one-cycle score increment strobe.
- render_req  out  1  held high until render_ack.
- game_state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 OVER.
- level  out  3  current speed level.
- overrun  out  1  sticky: a frame tick was dropped.

Behaviour:
- Reset values: all strobes 0, render_req 0, game_state IDLE, level 0, overrun 0, frame counter 0, level-frame counter 0, sequencer S_IDLE.
- Period = FRAME_DIV − level×SPEED_STEP. This is computed combinationally and is 16 bits wide. The period is sampled only at counter wrap, so a level change affects the next period only.
- Frame counter: counts only in RUN. At count == period−1 it wraps to 0 and raises tick for 1 cycle. It holds its value in PAUSE and clears on entry to RUN from IDLE/OVER.
- Game FSM:
  - IDLE --start_btn--> RUN.
  - RUN --collide--> OVER.
  - RUN --pause_btn--> PAUSE; PAUSE --pause_btn--> RUN.
  - OVER --start_btn--> RUN.
  - start_btn is ignored in RUN/PAUSE. collide is ignored outside RUN. pause_btn is ignored in IDLE/OVER.
  - In RUN, collide takes priority over pause_btn in the same cycle.
  - Entering RUN from IDLE/OVER clears level, the level-frame counter and overrun.
- Sequencer:
  - S_IDLE --tick--> S_PHYS (phys_stb=1) → S_SCROLL (scroll_stb=1) → S_SCORE (score_stb=1) → S_RENDER.
  - Each strobe lasts exactly 1 cycle. phys_stb is asserted the cycle after tick.
  - In S_RENDER, render_req=1 until the cycle render_ack is seen. render_req drops the following cycle and the sequencer returns to S_IDLE.
  - render_ack outside S_RENDER is ignored.
- Overrun: a tick while the sequencer is not in S_IDLE is dropped (never queued) and sets overrun=1.
- Level: on each render_ack the level-frame counter increments. At LEVEL_FRAMES−1 it wraps and level increments, saturating at LEVEL_MAX.
- Collide mid-sequence: the game state goes to OVER immediately, but the in-flight sequence completes through render so the crash frame is drawn. No further ticks are issued.
- Collide on the same cycle as a tick: OVER wins and the tick is discarded; no sequence starts.
- Pause mid-sequence: the sequence completes; the counter freezes.
- Reset mid-sequence: strobes and render_req drop asynchronously; render_ack arriving afterwards is ignored.

Optional Feature:
- Macro: REX_SCHED_STEP_EN.
- Defined: adds input port step_btn (1-bit pulse). In PAUSE with the sequencer in S_IDLE, step_btn starts exactly one full sequence.
  - Stepped frames count toward level.
  - The frame counter is not touched.
  - step_btn is ignored in other states or while the sequencer is busy.
- Undefined: the port is absent and PAUSE never issues strobes.

Decomposition:
- Shared package rex_pkg holds:
  - game state encodings (GS_IDLE..GS_OVER);
  - sequencer encodings (S_IDLE..S_RENDER);
  - LEVEL_W=3.
- One natural sub-module: rex_frame_timer, a programmable-period counter with enable, synchronous clear, period input and tick output.

Test Plan:
- Bench parameters: FRAME_DIV=20, SPEED_STEP=2, LEVEL_FRAMES=4.
- Reset then start_btn: game_state=1. The first tick falls 20 cycles after entering RUN; phys_stb, scroll_stb and score_stb follow on consecutive cycles; then render_req=1. With render_ack 3 cycles later, render_req falls the next cycle.
- Acking each frame immediately: after 4 render_acks level=1 and the next period is 18 cycles. After 28 frames level=7 and the period is 6 cycles; level stays 7 thereafter.
- Withhold render_ack for 25 cycles: overrun=1, and only one sequence is observed. A late ack returns the sequencer to S_IDLE.
- collide asserted the cycle phys_stb fires: game_state=3 next cycle. scroll, score and render still complete; no tick follows for 100 cycles. start_btn then gives level=0, overrun=0, game_state=1.
- pause_btn at counter=10: game_state=2 and the counter holds at 10 for 50 cycles. A second pause_btn resumes, and the tick arrives 10 cycles later. With REX_SCHED_STEP_EN, step_btn in PAUSE gives exactly one strobe triple plus render_req.
- Drop rstn while render_req=1: all outputs return to 0 immediately and game_state=0.
